// File: rtl/rr_spill_arbiter.sv
// Round-robin arbiter feeding a 2-entry spill FIFO (payload + source index).
// Latency: 1 cycle from input handshake to oup_valid_o when the FIFO is empty.
// Backpressure: inp_ready_o goes to 0 for every input while the FIFO is full or clear_i is high.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous flush of buffered entries and priority pointer
//   inp_valid_i/ready_o  per-input handshake; only the round-robin winner sees ready
//   inp_data_i           per-input payload
//   oup_valid_o/ready_i  buffered output handshake
//   oup_data_o/idx_o     head-of-FIFO payload and the index of the input that supplied it
module rr_spill_arbiter #(
  parameter int unsigned NumInp = 4,
  parameter type T = logic,
  localparam int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [NumInp-1:0]   inp_valid_i,
  output logic [NumInp-1:0]   inp_ready_o,
  input  T     [NumInp-1:0]   inp_data_i,
  output logic                oup_valid_o,
  input  logic                oup_ready_i,
  output T                    oup_data_o,
  output logic [IdxWidth-1:0] oup_idx_o
);

  logic [1:0]          wr_ptr_q, wr_ptr_d;
  logic [1:0]          rd_ptr_q, rd_ptr_d;
  T                    data_q [2];
  T                    data_d [2];
  logic [IdxWidth-1:0] idx_q [2];
  logic [IdxWidth-1:0] idx_d [2];
  logic [IdxWidth-1:0] rr_q, rr_d;

  logic [IdxWidth-1:0] win_idx;
  logic                win_vld;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  // (a + b) mod NumInp; both operands stay below NumInp, so one subtraction suffices.
  function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] a,
                                                   input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NumInp) s = s - NumInp;
    return s[IdxWidth-1:0];
  endfunction

  // First valid input, scanning upward from the priority pointer with wrap-around.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      if (!win_vld && inp_valid_i[wrap_add(rr_q, i)]) begin
        win_vld = 1'b1;
        win_idx = wrap_add(rr_q, i);
      end
    end
  end

  // Pointers carry one extra wrap bit: same value = empty, only MSB differs = full.
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == 2'b10);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Full is judged before this cycle's pop, so a full FIFO never accepts and drains together.
  assign push = win_vld & ~full & ~clear_i;
  assign pop  = ~empty & oup_ready_i;

  always_comb begin
    inp_ready_o = '0;
    if (push) inp_ready_o[win_idx] = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    if (clear_i) begin
      // Flush wins over any pop in the same cycle; entries are zeroed so the
      // output bus reads back 0 just as it does after reset.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      rr_d     = '0;
      for (int i = 0; i < 2; i++) begin
        data_d[i] = '0;
        idx_d[i]  = '0;
      end
    end else begin
      if (push) begin
        data_d[wr_ptr_q[0]] = inp_data_i[win_idx];
        idx_d[wr_ptr_q[0]]  = win_idx;
        wr_ptr_d            = wr_ptr_q + 2'd1;
        rr_d                = wrap_add(win_idx, 1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rr_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rr_q     <= rr_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
    end
  end

  // Outputs come straight from state; no input port reaches them combinationally.
  assign oup_valid_o = ~empty;
  assign oup_data_o  = data_q[rd_ptr_q[0]];
  assign oup_idx_o   = idx_q[rd_ptr_q[0]];

endmodule

// File: tb/tb_rr_spill_arbiter.sv
module tb_rr_spill_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 4-input instance
  logic            clear;
  logic [3:0]      vld;
  logic [3:0]      rdy;
  logic [3:0][7:0] dat;
  logic            ov;
  logic            ordy;
  logic [7:0]      od;
  logic [1:0]      oidx;

  // 3-input instance (non-power-of-two wrap)
  logic            clear3;
  logic [2:0]      vld3;
  logic [2:0]      rdy3;
  logic [2:0][7:0] dat3;
  logic            ov3;
  logic            ordy3;
  logic [7:0]      od3;
  logic [1:0]      oidx3;

  rr_spill_arbiter #(.NumInp(4), .T(logic [7:0])) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .inp_valid_i(vld), .inp_ready_o(rdy), .inp_data_i(dat),
    .oup_valid_o(ov), .oup_ready_i(ordy), .oup_data_o(od), .oup_idx_o(oidx)
  );

  rr_spill_arbiter #(.NumInp(3), .T(logic [7:0])) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear3),
    .inp_valid_i(vld3), .inp_ready_o(rdy3), .inp_data_i(dat3),
    .oup_valid_o(ov3), .oup_ready_i(ordy3), .oup_data_o(od3), .oup_idx_o(oidx3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Directed vector table for the 4-input instance. Expected values are taken
  // just before the rising edge that consumes the row's inputs.
  typedef struct {
    logic [3:0] vld;
    logic       clr;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [1:0] e_idx;
  } vec_t;

  vec_t tbl [20];

  // Reference model: a queue of accepted entries and an integer priority pointer.
  typedef struct {
    logic [7:0] d;
    int         idx;
  } ent_t;

  ent_t mq[$];
  int   mrr;
  int   ordy_pct;

  task automatic rand_cycle();
    int         win;
    int         k;
    logic [3:0] erdy;
    @(negedge clk);
    vld   = 4'($urandom);
    dat   = 32'($urandom);
    ordy  = ($urandom_range(99) < ordy_pct);
    clear = ($urandom_range(63) == 0);
    #1;
    win = -1;
    for (int o = 0; o < 4; o++) begin
      k = (mrr + o) % 4;
      if (win < 0 && vld[k]) win = k;
    end
    erdy = (win >= 0 && mq.size() < 2 && !clear) ? (4'b0001 << win) : 4'b0000;
    chk("rnd_ready", 32'(rdy), 32'(erdy));
    chk("rnd_ov", 32'(ov), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("rnd_idx", 32'(oidx), 32'(mq[0].idx));
      chk("rnd_data", 32'(od), 32'(mq[0].d));
    end
    if (clear) begin
      mq.delete();
      mrr = 0;
    end else begin
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (erdy != 4'b0000) begin
        mq.push_back('{dat[win], win});
        mrr = (win + 1) % 4;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[2]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd1};
    tbl[3]  = '{4'b1111, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd2};
    tbl[4]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd3};
    tbl[5]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[6]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[7]  = '{4'b0110, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd0};
    tbl[8]  = '{4'b0110, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd1};
    tbl[9]  = '{4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[10] = '{4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[11] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1};
    tbl[12] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2};
    tbl[13] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[14] = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd0};
    tbl[15] = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd3};
    tbl[16] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3};
    tbl[17] = '{4'b1111, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[18] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[19] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};

    rst_n  = 1'b0;
    clear  = 1'b0;
    vld    = '0;
    dat    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ordy   = 1'b0;
    clear3 = 1'b0;
    vld3   = '0;
    dat3   = {8'h32, 8'h31, 8'h30};
    ordy3  = 1'b1;

    // Reset state, during and after reset
    #12;
    chk("rst_ov", 32'(ov), 0);
    chk("rst_data", 32'(od), 0);
    chk("rst_idx", 32'(oidx), 0);
    chk("rst_ready", 32'(rdy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ov", 32'(ov), 0);
    chk("post_rst_ready", 32'(rdy), 0);

    // Directed table: rotation, fill-to-full with stall, clear while full
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vld   = tbl[i].vld;
      clear = tbl[i].clr;
      ordy  = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_ov", i), 32'(ov), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d_idx", i), 32'(oidx), 32'(tbl[i].e_idx));
        chk($sformatf("tbl%0d_data", i), 32'(od), 32'(8'hA0 + 8'(tbl[i].e_idx)));
      end
    end
    clear = 1'b0;

    // One entry held while pushing and popping every cycle: order preserved
    @(negedge clk);
    vld    = 4'b0001;
    dat[0] = 8'h10;
    ordy   = 1'b1;
    #1;
    chk("pp_first_ready", 32'(rdy), 32'(4'b0001));
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      dat[0] = 8'h10 + 8'(j);
      #1;
      chk($sformatf("pp%0d_ov", j), 32'(ov), 1);
      chk($sformatf("pp%0d_data", j), 32'(od), 32'(8'h10 + 8'(j - 1)));
      chk($sformatf("pp%0d_ready", j), 32'(rdy), 32'(4'b0001));
    end
    @(negedge clk);
    vld = 4'b0000;
    #1;
    chk("pp_last_data", 32'(od), 32'h1A);
    @(negedge clk);
    #1;
    chk("pp_drained_ov", 32'(ov), 0);
    dat[0] = 8'hA0;

    // Reset asserted mid-cycle with two entries buffered
    @(negedge clk);
    vld  = 4'b0011;
    ordy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vld = 4'b0000;
    #1;
    chk("arst_pre_ov", 32'(ov), 1);
    chk("arst_pre_full", 32'(rdy), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(ov), 0);
    chk("arst_data", 32'(od), 0);
    chk("arst_idx", 32'(oidx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ordy  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #1;
      chk($sformatf("arst_stale%0d_ov", j), 32'(ov), 0);
    end

    // 3-input instance: lone input 2 twice (pointer wraps to 0), then 0 beats 1
    @(negedge clk);
    vld3 = 3'b100;
    #1;
    chk("n3_c0_ready", 32'(rdy3), 32'(3'b100));
    chk("n3_c0_ov", 32'(ov3), 0);
    @(negedge clk);
    #1;
    chk("n3_c1_ready", 32'(rdy3), 32'(3'b100));
    chk("n3_c1_idx", 32'(oidx3), 2);
    chk("n3_c1_data", 32'(od3), 32'h32);
    @(negedge clk);
    vld3 = 3'b011;
    #1;
    chk("n3_c2_ready", 32'(rdy3), 32'(3'b001));
    chk("n3_c2_idx", 32'(oidx3), 2);
    @(negedge clk);
    #1;
    chk("n3_c3_ready", 32'(rdy3), 32'(3'b010));
    chk("n3_c3_idx", 32'(oidx3), 0);
    chk("n3_c3_data", 32'(od3), 32'h30);
    @(negedge clk);
    vld3 = 3'b000;
    #1;
    chk("n3_c4_idx", 32'(oidx3), 1);
    chk("n3_c4_ov", 32'(ov3), 1);
    @(negedge clk);
    #1;
    chk("n3_c5_ov", 32'(ov3), 0);

    // Randomized traffic against the queue model (DUT is empty with pointer 0 here)
    mq.delete();
    mrr = 0;
    for (int blk = 0; blk < 15; blk++) begin
      ordy_pct = $urandom_range(100);
      for (int c = 0; c < 200; c++) rand_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_spill_arbiter.md
RR_SPILL_ARBITER -- requirements
Module: rr_spill_arbiter

Interface
REQ-001 SHALL have parameter NumInp, default 4, number of requesting input streams; legal range 1..64.
REQ-002 SHALL have parameter T, default logic, payload type of every stream.
REQ-003 SHALL define IdxWidth = max(1, clog2(NumInp)) as a local parameter.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all state samples on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port clear_i, input, 1, synchronous flush of buffer and priority.
REQ-007 SHALL have port inp_valid_i, input, NumInp, per-input valid.
REQ-008 SHALL have port inp_ready_o, output, NumInp, per-input ready.
REQ-009 SHALL have port inp_data_i, input, NumInp x T, per-input payload.
REQ-010 SHALL have port oup_valid_o, output, 1, buffered output valid.
REQ-011 SHALL have port oup_ready_i, input, 1, downstream ready.
REQ-012 SHALL have port oup_data_o, output, T, buffered payload.
REQ-013 SHALL have port oup_idx_o, output, IdxWidth, index of the input that supplied oup_data_o.

Function
REQ-014 SHALL hold a 2-entry FIFO (entries: payload + index) with 2-bit write/read pointers; full when pointers differ only in MSB, empty when equal.
REQ-015 SHALL hold a round-robin priority pointer rr_q (IdxWidth bits), range 0..NumInp-1.
REQ-016 SHALL select winner = first index k with inp_valid_i[k]=1, searching rr_q, rr_q+1, ... modulo NumInp.
REQ-017 SHALL assert inp_ready_o[k] only for the winner, only when FIFO not full and clear_i=0; all other bits 0.
REQ-018 SHALL push {inp_data_i[k], k} into FIFO on inp_valid_i[k] && inp_ready_o[k]; at most one push per cycle.
REQ-019 SHALL update rr_q <= (k+1) mod NumInp on push only; no push -> rr_q holds (winner k=NumInp-1 wraps to 0).
REQ-020 SHALL drive oup_valid_o = FIFO not empty, oup_data_o/oup_idx_o = entry at read pointer, directly from registers.
REQ-021 SHALL pop on oup_valid_o && oup_ready_i.
REQ-022 SHALL have no combinational path from any input port to any output port except inputs -> inp_ready_o (valid-dependent selection) and clear_i -> inp_ready_o.
REQ-023 SHALL give latency of exactly 1 cycle from input handshake to oup_valid_o when FIFO was empty.
REQ-024 SHALL sustain 1 transfer/cycle when oup_ready_i is held 1.
REQ-025 SHALL on simultaneous push and pop with FIFO full: no push (ready 0 that cycle), pop only.
REQ-026 SHALL on simultaneous push and pop with 1 entry: both occur, occupancy stays 1.
REQ-027 SHALL on clear_i=1: no push, discard all entries (pointers to 0), rr_q <= 0, next-cycle oup_valid_o=0; clear overrides simultaneous pop.
REQ-028 SHALL keep oup_valid_o, oup_data_o, oup_idx_o stable while oup_valid_o && !oup_ready_i.
REQ-029 SHALL with NumInp=1 act as plain 2-entry spill buffer, oup_idx_o constant 0.
REQ-030 SHALL support non-power-of-two NumInp (e.g. 3) with correct wrap of rr_q.

Reset
REQ-031 SHALL on rst_ni=0 asynchronously set FIFO pointers 0, rr_q 0, all FIFO entries 0.
REQ-032 SHALL during and after reset drive oup_valid_o=0, oup_data_o=0, oup_idx_o=0, inp_ready_o=0 while no input valid.
REQ-033 SHALL on reset mid-operation drop all buffered entries; no entry is delivered after rst_ni rises.

Verification
REQ-034 SHALL cover: NumInp=4, all valid held, oup_ready_i=1 -> oup_idx_o sequence 0,1,2,3,0,... one per cycle after 1-cycle latency.
REQ-035 SHALL cover: oup_ready_i=0, inputs 1,2 valid -> accept idx1 then idx2, then inp_ready_o=0000 (full), oup_data_o stable on idx1 payload.
REQ-036 SHALL cover: NumInp=3, only input 2 valid twice -> rr_q 0->0 after 2 wraps to 0; idx 2,2 output; then inputs 0,1 valid -> idx 0 first.
REQ-037 SHALL cover: FIFO with 1 entry, push and pop same cycle for 10 cycles -> oup_valid_o stays 1, order preserved.
REQ-038 SHALL cover: FIFO full, clear_i=1 with inp_valid_i=1111 -> inp_ready_o=0000, next cycle oup_valid_o=0, next winner idx 0.
REQ-039 SHALL cover: rst_ni pulsed low with 2 entries buffered -> oup_valid_o=0 immediately (asynchronously), no stale entry after release.
